// File: rtl/bf_uart.sv
// bf_uart: 8N1 UART transceiver (LSB first, idle-high) with a fractional 16x baud generator.
// Define UART_BAUD_CLK_EN to expose the internal 16x tick on o_baud_clk; otherwise it reads 0.

module bf_uart (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ser_in,
  output logic        o_ser_out,
  output logic [7:0]  o_rx_data,
  output logic        o_new_rx_data,
  input  logic [7:0]  i_tx_data,
  input  logic        i_new_tx_data,
  output logic        o_tx_busy,
  input  logic [11:0] i_baud_freq,
  input  logic [15:0] i_baud_limit,
  output logic        o_baud_clk
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BIT_W  = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(7);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Fractional baud accumulator producing a one-cycle 16x tick
  logic [ACC_W-1:0] r_acc;
  logic             r_tick;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (r_acc >= i_baud_limit) begin
      r_acc  <= r_acc - i_baud_limit;
      r_tick <= 1'b1;
    end else begin
      r_acc  <= r_acc + ACC_W'(i_baud_freq);
      r_tick <= 1'b0;
    end
  end

`ifdef UART_BAUD_CLK_EN
  assign o_baud_clk = r_tick;
`else
  assign o_baud_clk = 1'b0;
`endif

  // Two-flop synchronizer on the asynchronous serial input
  logic r_rx_sync1;
  logic r_rx_sync2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
    end else begin
      r_rx_sync1 <= i_ser_in;
      r_rx_sync2 <= r_rx_sync1;
    end
  end

  // Receiver
  rx_state_t         r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0]  r_rx_cnt, w_rx_cnt_nxt;
  logic [BIT_W-1:0]  r_rx_bit, w_rx_bit_nxt;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_new_rx_data, w_new_rx_data_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_state    <= RX_IDLE;
      r_rx_cnt      <= '0;
      r_rx_bit      <= '0;
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_new_rx_data <= 1'b0;
    end else begin
      r_rx_state    <= w_rx_state_nxt;
      r_rx_cnt      <= w_rx_cnt_nxt;
      r_rx_bit      <= w_rx_bit_nxt;
      r_rx_shift    <= w_rx_shift_nxt;
      r_rx_data     <= w_rx_data_nxt;
      r_new_rx_data <= w_new_rx_data_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt    = r_rx_state;
    w_rx_cnt_nxt      = r_rx_cnt;
    w_rx_bit_nxt      = r_rx_bit;
    w_rx_shift_nxt    = r_rx_shift;
    w_rx_data_nxt     = r_rx_data;
    w_new_rx_data_nxt = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (!r_rx_sync2) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_tick) begin
          if (r_rx_cnt == CNT_HALF) begin
            // Line back high at mid start bit: treat as a glitch
            w_rx_cnt_nxt   = '0;
            w_rx_bit_nxt   = '0;
            w_rx_state_nxt = r_rx_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
          end
        end
      end
      RX_DATA: begin
        if (r_tick) begin
          if (r_rx_cnt == CNT_LAST) begin
            w_rx_cnt_nxt   = '0;
            w_rx_shift_nxt = {r_rx_sync2, r_rx_shift[DATA_W-1:1]};
            if (r_rx_bit == BIT_LAST) w_rx_state_nxt = RX_STOP;
            else                      w_rx_bit_nxt   = r_rx_bit + BIT_W'(1);
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (r_tick) begin
          if (r_rx_cnt == CNT_LAST) begin
            // Stop bit low is a framing error: drop the byte silently
            w_rx_cnt_nxt   = '0;
            w_rx_state_nxt = RX_IDLE;
            if (r_rx_sync2) begin
              w_rx_data_nxt     = r_rx_shift;
              w_new_rx_data_nxt = 1'b1;
            end
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
          end
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign o_rx_data     = r_rx_data;
  assign o_new_rx_data = r_new_rx_data;

  // Transmitter
  tx_state_t         r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0]  r_tx_cnt, w_tx_cnt_nxt;
  logic [BIT_W-1:0]  r_tx_bit, w_tx_bit_nxt;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nxt;
  logic              r_tx_wait, w_tx_wait_nxt;
  logic              r_ser_out, w_ser_out_nxt;
  logic              r_tx_busy, w_tx_busy_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_wait  <= 1'b0;
      r_ser_out  <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_wait  <= w_tx_wait_nxt;
      r_ser_out  <= w_ser_out_nxt;
      r_tx_busy  <= w_tx_busy_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_wait_nxt  = r_tx_wait;
    w_ser_out_nxt  = r_ser_out;
    w_tx_busy_nxt  = r_tx_busy;
    case (r_tx_state)
      TX_IDLE: begin
        if (i_new_tx_data) begin
          w_tx_shift_nxt = i_tx_data;
          w_tx_busy_nxt  = 1'b1;
          w_tx_wait_nxt  = 1'b1;
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        // First tick after acceptance opens the start bit on the tick grid
        if (r_tick) begin
          if (r_tx_wait) begin
            w_tx_wait_nxt = 1'b0;
            w_ser_out_nxt = 1'b0;
          end else if (r_tx_cnt == CNT_LAST) begin
            w_tx_cnt_nxt   = '0;
            w_ser_out_nxt  = r_tx_shift[0];
            w_tx_state_nxt = TX_DATA;
          end else begin
            w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
          end
        end
      end
      TX_DATA: begin
        if (r_tick) begin
          if (r_tx_cnt == CNT_LAST) begin
            w_tx_cnt_nxt = '0;
            if (r_tx_bit == BIT_LAST) begin
              w_ser_out_nxt  = 1'b1;
              w_tx_state_nxt = TX_STOP;
            end else begin
              w_tx_bit_nxt   = r_tx_bit + BIT_W'(1);
              w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_W-1:1]};
              w_ser_out_nxt  = r_tx_shift[1];
            end
          end else begin
            w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (r_tick) begin
          if (r_tx_cnt == CNT_LAST) begin
            w_tx_cnt_nxt   = '0;
            w_tx_busy_nxt  = 1'b0;
            w_tx_state_nxt = TX_IDLE;
          end else begin
            w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign o_ser_out = r_ser_out;
  assign o_tx_busy = r_tx_busy;

endmodule

// File: tb/tb_bf_uart.sv
// Self-checking bench for bf_uart: frame-level reference model (bit periods from the baud
// formula, expected frames as {stop, data, start}) against randomized and directed traffic.

module tb_bf_uart;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser_drv;
  logic        lb;
  logic        ser_in;
  logic        ser_out;
  logic [7:0]  rx_data;
  logic        new_rx_data;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic [11:0] baud_freq;
  logic [15:0] baud_limit;
  logic        baud_clk;

  always #5 clk = ~clk;

  assign ser_in = lb ? ser_out : ser_drv;

  bf_uart dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ser_in      (ser_in),
    .o_ser_out     (ser_out),
    .o_rx_data     (rx_data),
    .o_new_rx_data (new_rx_data),
    .i_tx_data     (tx_data),
    .i_new_tx_data (new_tx_data),
    .o_tx_busy     (tx_busy),
    .i_baud_freq   (baud_freq),
    .i_baud_limit  (baud_limit),
    .o_baud_clk    (baud_clk)
  );

  int checks = 0;
  int errors = 0;

  // Bit period in clocks is bit_num/bit_den = 16*(freq+limit)/freq
  int bit_num;
  int bit_den;
  logic [7:0] last_rx;
  logic [7:0] rx_q[$];

  logic [9:0] cap_bits;
  int         cap_edges[$];
  logic       cap_timeout;
  logic       cap_busy_held;
  logic       cap_busy_end;

  always @(negedge clk) if (new_rx_data === 1'b1) rx_q.push_back(rx_data);

  function automatic logic [9:0] frame_of(input logic [7:0] d);
    frame_of = {1'b1, d, 1'b0};
  endfunction

  task automatic do_reset(input logic [11:0] f, input logic [15:0] l);
    rst_n = 1'b0;
    baud_freq = f;
    baud_limit = l;
    bit_num = 16 * (int'(f) + int'(l));
    bit_den = int'(f);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    last_rx = 8'h00;
    rx_q.delete();
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    new_tx_data = 1'b1;
    @(negedge clk);
    new_tx_data = 1'b0;
    tx_data = 8'($urandom);
  endtask

  // Record one transmitted frame: mid-bit levels, edge times relative to the start edge, busy
  task automatic capture_tx();
    int n;
    int frame_len;
    logic prev;
    cap_edges.delete();
    cap_bits = '1;
    cap_timeout = 1'b0;
    cap_busy_held = 1'b1;
    cap_busy_end = 1'b1;
    n = 0;
    while (ser_out !== 1'b0 && n < 2 * bit_num / bit_den) begin
      @(negedge clk);
      n++;
    end
    if (ser_out !== 1'b0) begin
      cap_timeout = 1'b1;
      return;
    end
    frame_len = (10 * bit_num) / bit_den;
    prev = 1'b0;
    for (int c = 1; c <= frame_len + 4; c++) begin
      @(negedge clk);
      if (ser_out !== prev) begin
        cap_edges.push_back(c);
        prev = ser_out;
      end
      for (int k = 0; k < 10; k++)
        if (c == ((2 * k + 1) * bit_num) / (2 * bit_den)) cap_bits[k] = ser_out;
      if (c < frame_len - 3 && tx_busy !== 1'b1) cap_busy_held = 1'b0;
      if (c == frame_len + 4) cap_busy_end = tx_busy;
    end
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop_val);
    logic [9:0] f;
    int t;
    int t_end;
    f = {stop_val, d, 1'b0};
    t = 0;
    for (int k = 0; k < 10; k++) begin
      ser_drv = f[k];
      t_end = ((k + 1) * bit_num) / bit_den;
      // A bad stop bit is held low for 3/4 bit so the follow-up restart resolves as a glitch
      if (k == 9 && !stop_val) t_end = (9 * bit_num) / bit_den + (3 * bit_num) / (4 * bit_den);
      while (t < t_end) begin
        @(negedge clk);
        t++;
      end
    end
    ser_drv = 1'b1;
    repeat (bit_num / bit_den) @(negedge clk);
  endtask

  task automatic test_reset();
    lb = 1'b0;
    ser_drv = 1'b1;
    tx_data = 8'h00;
    new_tx_data = 1'b0;
    baud_freq = 12'd4;
    baud_limit = 16'd621;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL reset_ser_out: got %b expected 1", ser_out); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    checks++; if (new_rx_data !== 1'b0) begin errors++; $display("FAIL reset_new_rx_data: got %b expected 0", new_rx_data); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (baud_clk !== 1'b0) begin errors++; $display("FAIL reset_baud_clk: got %b expected 0", baud_clk); end
  endtask

  task automatic test_baud_rate();
    int cnt;
    int exp_cnt;
    do_reset(12'd4, 16'd621);
    cnt = 0;
    repeat (10000) begin
      @(negedge clk);
      if (baud_clk === 1'b1) cnt++;
    end
`ifdef UART_BAUD_CLK_EN
    exp_cnt = 64;
`else
    exp_cnt = 0;
`endif
    checks++; if (cnt != exp_cnt) begin errors++; $display("FAIL baud_clk_count: got %0d expected %0d", cnt, exp_cnt); end
  endtask

  task automatic test_tx_a5();
    logic [9:0] f;
    int exp_e[$];
    f = frame_of(8'hA5);
    for (int k = 1; k < 10; k++) if (f[k] != f[k-1]) exp_e.push_back((k * bit_num) / bit_den);
    start_tx(8'hA5);
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_accept_busy: got %b expected 1", tx_busy); end
    capture_tx();
    checks++; if (cap_timeout !== 1'b0) begin errors++; $display("FAIL tx_a5_start: no start bit seen"); end
    checks++; if (cap_bits !== f) begin errors++; $display("FAIL tx_a5_bits: got %b expected %b", cap_bits, f); end
    checks++;
    if (cap_edges.size() != exp_e.size()) begin
      errors++; $display("FAIL tx_a5_edge_count: got %0d expected %0d", cap_edges.size(), exp_e.size());
    end
    for (int j = 0; j < exp_e.size() && j < cap_edges.size(); j++) begin
      checks++;
      if (cap_edges[j] < exp_e[j] - 1 || cap_edges[j] > exp_e[j] + 1) begin
        errors++; $display("FAIL tx_a5_edge%0d: got cycle %0d expected %0d +-1", j, cap_edges[j], exp_e[j]);
      end
    end
    checks++; if (cap_busy_held !== 1'b1) begin errors++; $display("FAIL tx_a5_busy_held: got %b expected 1", cap_busy_held); end
    checks++; if (cap_busy_end !== 1'b0) begin errors++; $display("FAIL tx_a5_busy_end: got %b expected 0", cap_busy_end); end
  endtask

  task automatic test_rx_frame();
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 8'h3C : 8'($urandom);
      rx_q.delete();
      drive_rx(d, 1'b1);
      checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL rx_pulses[%0d]: got %0d expected 1", i, rx_q.size()); end
      checks++;
      if (rx_q.size() < 1 || rx_q[0] !== d) begin
        errors++; $display("FAIL rx_byte[%0d]: got %h expected %h", i, (rx_q.size() > 0) ? rx_q[0] : 8'hxx, d);
      end
      checks++; if (rx_data !== d) begin errors++; $display("FAIL rx_data_hold[%0d]: got %h expected %h", i, rx_data, d); end
      last_rx = d;
    end
  endtask

  task automatic test_rx_glitch();
    rx_q.delete();
    ser_drv = 1'b0;
    repeat (bit_num / (5 * bit_den)) @(negedge clk);
    ser_drv = 1'b1;
    repeat (2 * bit_num / bit_den) @(negedge clk);
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL rx_glitch_pulse: got %0d expected 0", rx_q.size()); end
    checks++; if (rx_data !== last_rx) begin errors++; $display("FAIL rx_glitch_data: got %h expected %h", rx_data, last_rx); end
  endtask

  task automatic test_framing_error();
    rx_q.delete();
    drive_rx(8'h55, 1'b0);
    repeat (2 * bit_num / bit_den) @(negedge clk);
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL frame_err_pulse: got %0d expected 0", rx_q.size()); end
    checks++; if (rx_data !== last_rx) begin errors++; $display("FAIL frame_err_data: got %h expected %h", rx_data, last_rx); end
    drive_rx(8'h12, 1'b1);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h12) begin
      errors++; $display("FAIL frame_err_recover: got %0d bytes first %h expected 1 byte 12", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    last_rx = 8'h12;
  endtask

  task automatic test_tx_random();
    logic [7:0] d;
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      start_tx(d);
      capture_tx();
      checks++; if (cap_bits !== frame_of(d)) begin errors++; $display("FAIL tx_rand_bits[%0d]: got %b expected %b", i, cap_bits, frame_of(d)); end
      checks++; if (cap_busy_end !== 1'b0) begin errors++; $display("FAIL tx_rand_busy_end[%0d]: got %b expected 0", i, cap_busy_end); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] d1;
    int lows;
    d1 = 8'($urandom);
    start_tx(d1);
    fork
      capture_tx();
      begin
        repeat (3 * bit_num / bit_den) @(negedge clk);
        tx_data = ~d1;
        new_tx_data = 1'b1;
        @(negedge clk);
        new_tx_data = 1'b0;
      end
    join
    checks++; if (cap_bits !== frame_of(d1)) begin errors++; $display("FAIL busy_ignore_bits: got %b expected %b", cap_bits, frame_of(d1)); end
    lows = 0;
    repeat (2 * bit_num / bit_den) begin
      @(negedge clk);
      if (ser_out !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL busy_ignore_second_frame: got %0d active cycles expected 0", lows); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    int lowcnt;
    int n;
    int frame;
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h80;
    frame = (10 * bit_num) / bit_den;
    lb = 1'b1;
    rx_q.delete();
    @(negedge clk);
    tx_data = seq[0];
    new_tx_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lowcnt = 0;
      do begin
        @(negedge clk);
        if (tx_busy !== 1'b1) lowcnt++;
      end while (tx_busy !== 1'b1 && lowcnt < 50);
      checks++; if (lowcnt != 0) begin errors++; $display("FAIL b2b_accept[%0d]: got %0d extra idle cycles expected 0", i, lowcnt); end
      if (i < 2) tx_data = seq[i+1];
      else new_tx_data = 1'b0;
      n = 0;
      while (tx_busy === 1'b1 && n < 2 * frame) begin
        @(negedge clk);
        n++;
      end
      checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall[%0d]: got %b expected 0", i, tx_busy); end
    end
    new_tx_data = 1'b0;
    repeat (bit_num / bit_den) @(negedge clk);
    checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", rx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== seq[i]) begin
        errors++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, seq[i]);
      end
    end
    last_rx = seq[2];
    lb = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int lows;
    start_tx(8'($urandom));
    n = 0;
    while (ser_out !== 1'b0 && n < 2 * bit_num / bit_den) begin
      @(negedge clk);
      n++;
    end
    repeat (bit_num / (2 * bit_den)) @(negedge clk);
    checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL mid_frame_start_bit: got %b expected 0", ser_out); end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL mid_frame_busy: got %b expected 1", tx_busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL mid_reset_ser_out: got %b expected 1", ser_out); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_tx_busy: got %b expected 0", tx_busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_rx_data: got %h expected 00", rx_data); end
    rst_n = 1'b1;
    last_rx = 8'h00;
    lows = 0;
    repeat (2 * bit_num / bit_den) begin
      @(negedge clk);
      if (ser_out !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL mid_reset_resume: got %0d low cycles expected 0", lows); end
  endtask

  initial begin
    test_reset();
    test_baud_rate();
    test_tx_a5();
    do_reset(12'd7, 16'd121);
    test_rx_frame();
    test_rx_glitch();
    test_framing_error();
    test_tx_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
